// File: rtl/ipselector_cpu_debug_cmd_sysclk_if.sv
// Command stream between the sysclk debug decoder and its CPU-side consumer.
// Show-ahead: cmd_op/cmd_data are valid whenever cmd_valid is high.
interface ipselector_cpu_debug_cmd_sysclk_if #(
  parameter int unsigned SR_W = 38,
  parameter int unsigned IR_W = 2
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [IR_W-1:0] cmd_op;
  logic [SR_W-1:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/ipselector_cpu_debug_cmd_sysclk.sv
// System-clock side of the CPU JTAG debug slave.
// Synchronises TCK-domain update-IR / exit1-DR levels, captures the IR opcode and DR data,
// queues commands in a show-ahead FIFO and turns each accepted command into a registered
// jdo word plus a one-hot take_action / take_no_action strobe.
module ipselector_cpu_debug_cmd_sysclk #(
  parameter int unsigned SR_W        = 38,
  parameter int unsigned IR_W        = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FIFO_DEPTH  = 4,
  localparam int unsigned NOPS       = 2 ** IR_W,
  localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                vs_uir,
  input  logic                                vs_e1dr,
  input  logic [IR_W-1:0]                     ir_in,
  input  logic [SR_W-1:0]                     sr,
  input  logic                                ovf_clr,
  ipselector_cpu_debug_cmd_sysclk_if.master   cmd,
  output logic [SR_W-1:0]                     jdo,
  output logic [NOPS-1:0]                     take_action,
  output logic [NOPS-1:0]                     take_no_action,
  output logic [LVL_W-1:0]                    fifo_level,
  output logic                                overflow
);

  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned EW      = IR_W + SR_W;
  localparam int unsigned ARM_MAX = SYNC_STAGES + 1;
  localparam int unsigned ARM_W   = $clog2(ARM_MAX + 1);

  // Synchroniser and edge-detect state
  logic [SYNC_STAGES-1:0] uir_sync_q, e1dr_sync_q;
  logic                   uir_prev_q, e1dr_prev_q;
  logic [ARM_W-1:0]       arm_cnt_q;
  logic                   armed;
  logic                   uir_edge, e1dr_edge;

  // Captured opcode
  logic [IR_W-1:0]        ir_q;

  // FIFO state
  logic [EW-1:0]          mem_q [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]       count_q, count_d;
  logic                   full, valid, pop, push, drop;
  logic [EW-1:0]          head;

  // Accept outputs
  logic [SR_W-1:0]        jdo_q;
  logic [NOPS-1:0]        take_action_q, take_no_action_q;
  logic [NOPS-1:0]        lane_onehot;
  logic                   overflow_q;

  // Two-flop (or deeper) synchronisers plus previous-value flops for rising-edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      uir_sync_q  <= '0;
      e1dr_sync_q <= '0;
      uir_prev_q  <= 1'b0;
      e1dr_prev_q <= 1'b0;
    end else begin
      uir_sync_q  <= {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
      e1dr_sync_q <= {e1dr_sync_q[SYNC_STAGES-2:0], vs_e1dr};
      uir_prev_q  <= uir_sync_q[SYNC_STAGES-1];
      e1dr_prev_q <= e1dr_sync_q[SYNC_STAGES-1];
    end
  end

  // Arming counter: masks the edge an already-high input would fake right after reset release
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arm_cnt_q <= '0;
    end else if (!armed) begin
      arm_cnt_q <= arm_cnt_q + ARM_W'(1);
    end
  end

  assign armed     = (arm_cnt_q == ARM_W'(ARM_MAX));
  assign uir_edge  = armed & uir_sync_q[SYNC_STAGES-1] & ~uir_prev_q;
  assign e1dr_edge = armed & e1dr_sync_q[SYNC_STAGES-1] & ~e1dr_prev_q;

  // Opcode capture on update-IR; a coincident push still sees the old value
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir_q <= '0;
    end else if (uir_edge) begin
      ir_q <= ir_in;
    end
  end

  // FIFO control: a full queue still accepts a push when a pop happens in the same cycle
  always_comb begin
    full    = (count_q == LVL_W'(FIFO_DEPTH));
    valid   = (count_q != '0);
    pop     = valid & cmd.cmd_ready;
    push    = e1dr_edge & (~full | pop);
    drop    = e1dr_edge & full & ~pop;
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + LVL_W'(1);
      2'b01:   count_d = count_q - LVL_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // FIFO storage; contents are don't-care while not counted, so no reset
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {ir_q, sr};
  end

  // Show-ahead head, forced to zero while empty so outputs stay clean
  always_comb begin
    head          = valid ? mem_q[rd_ptr_q] : '0;
    cmd.cmd_valid = valid;
    cmd.cmd_op    = head[EW-1 -: IR_W];
    cmd.cmd_data  = head[SR_W-1:0];
    lane_onehot   = NOPS'(1) << cmd.cmd_op;
  end

  // Registered accept: latch jdo and fire exactly one strobe lane for one cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      jdo_q            <= '0;
      take_action_q    <= '0;
      take_no_action_q <= '0;
    end else begin
      take_action_q    <= '0;
      take_no_action_q <= '0;
      if (pop) begin
        jdo_q <= cmd.cmd_data;
        if (cmd.cmd_data[SR_W-1]) take_action_q    <= lane_onehot;
        else                      take_no_action_q <= lane_onehot;
      end
    end
  end

  // Sticky overflow; a new drop wins over a coincident clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end else if (ovf_clr) begin
      overflow_q <= 1'b0;
    end
  end

  assign jdo            = jdo_q;
  assign take_action    = take_action_q;
  assign take_no_action = take_no_action_q;
  assign fifo_level     = count_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_ipselector_cpu_debug_cmd_sysclk.sv
// Directed bench for the sysclk debug command decoder with a scoreboard of expected commands.
module tb_ipselector_cpu_debug_cmd_sysclk;

  localparam int unsigned SR_W = 38;
  localparam int unsigned IR_W = 2;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            vs_uir, vs_e1dr, ovf_clr;
  logic [IR_W-1:0] ir_in;
  logic [SR_W-1:0] sr;
  logic [SR_W-1:0] jdo;
  logic [3:0]      take_action, take_no_action;
  logic [2:0]      fifo_level;
  logic            overflow;

  ipselector_cpu_debug_cmd_sysclk_if #(.SR_W(SR_W), .IR_W(IR_W)) cmd_bus ();

  ipselector_cpu_debug_cmd_sysclk #(
    .SR_W        (SR_W),
    .IR_W        (IR_W),
    .SYNC_STAGES (2),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .vs_uir         (vs_uir),
    .vs_e1dr        (vs_e1dr),
    .ir_in          (ir_in),
    .sr             (sr),
    .ovf_clr        (ovf_clr),
    .cmd            (cmd_bus),
    .jdo            (jdo),
    .take_action    (take_action),
    .take_no_action (take_no_action),
    .fifo_level     (fifo_level),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [IR_W+SR_W-1:0] sb[$];
  logic [IR_W-1:0]      exp_ir = '0;
  logic [3:0]           exp_ta = '0, exp_tna = '0;
  logic [SR_W-1:0]      exp_jdo = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_uir(input logic [IR_W-1:0] op);
    ir_in  = op;
    vs_uir = 1'b1;
    tick(3);
    vs_uir = 1'b0;
    tick(3);
    exp_ir = op;
  endtask

  task automatic pulse_e1dr(input logic [SR_W-1:0] data, input bit expect_push);
    sr      = data;
    vs_e1dr = 1'b1;
    if (expect_push) sb.push_back({exp_ir, data});
    tick(3);
    vs_e1dr = 1'b0;
    tick(3);
  endtask

  // Monitor: strobes/jdo follow the accept seen one cycle earlier; accepted head must match queue
  always @(negedge clk) begin
    logic [IR_W+SR_W-1:0] e;
    if (!reset_n) begin
      exp_ta  = '0;
      exp_tna = '0;
      exp_jdo = '0;
    end else begin
      check("take_action", take_action, exp_ta);
      check("take_no_action", take_no_action, exp_tna);
      check("jdo", jdo, exp_jdo);
      exp_ta  = '0;
      exp_tna = '0;
      if (cmd_bus.cmd_valid && cmd_bus.cmd_ready) begin
        check("sb_has_entry", sb.size() == 0, 0);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("cmd_op", cmd_bus.cmd_op, e[IR_W+SR_W-1 -: IR_W]);
          check("cmd_data", cmd_bus.cmd_data, e[SR_W-1:0]);
          exp_jdo = e[SR_W-1:0];
          if (e[SR_W-1]) exp_ta  = 4'b0001 << e[IR_W+SR_W-1 -: IR_W];
          else           exp_tna = 4'b0001 << e[IR_W+SR_W-1 -: IR_W];
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    vs_uir = 1'b0; vs_e1dr = 1'b0; ovf_clr = 1'b0;
    ir_in = '0; sr = '0;
    cmd_bus.cmd_ready = 1'b0;
    #3;
    check("rst_cmd_valid", cmd_bus.cmd_valid, 0);
    check("rst_fifo_level", fifo_level, 0);
    check("rst_overflow", overflow, 0);
    check("rst_jdo", jdo, 0);
    check("rst_strobes", {take_action, take_no_action}, 0);
    tick(2);
    reset_n = 1'b1;
    tick(5);

    // 1: action command, exact latency
    cmd_bus.cmd_ready = 1'b1;
    pulse_uir(2'b01);
    sr = 38'h20_DEAD_BEEF;
    vs_e1dr = 1'b1;
    sb.push_back({exp_ir, sr});
    tick(2);
    check("t1_valid_early", cmd_bus.cmd_valid, 0);
    tick(1);
    check("t1_valid_lat3", cmd_bus.cmd_valid, 1);
    check("t1_head_op", cmd_bus.cmd_op, 2'b01);
    vs_e1dr = 1'b0;
    tick(1);
    check("t1_take_action", take_action, 4'b0010);
    check("t1_take_no_action", take_no_action, 4'b0000);
    check("t1_jdo", jdo, 38'h20_DEAD_BEEF);
    tick(1);
    check("t1_strobe_1cyc", take_action, 4'b0000);
    tick(2);

    // 2: no-action command on lane 3
    pulse_uir(2'b11);
    sr = 38'h0F_1234_5678;
    vs_e1dr = 1'b1;
    sb.push_back({exp_ir, sr});
    tick(3);
    vs_e1dr = 1'b0;
    tick(1);
    check("t2_take_no_action", take_no_action, 4'b1000);
    check("t2_take_action", take_action, 4'b0000);
    tick(3);

    // 3: overflow with stalled consumer, then drain and clear
    cmd_bus.cmd_ready = 1'b0;
    for (int i = 1; i <= 5; i++) pulse_e1dr(SR_W'(i), i <= 4);
    check("t3_level_full", fifo_level, 4);
    check("t3_overflow_set", overflow, 1);
    cmd_bus.cmd_ready = 1'b1;
    tick(6);
    check("t3_level_drained", fifo_level, 0);
    check("t3_sb_empty", sb.size(), 0);
    check("t3_overflow_sticky", overflow, 1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    check("t3_overflow_clr", overflow, 0);

    // 4: full FIFO, push coincides with a pop
    cmd_bus.cmd_ready = 1'b0;
    for (int i = 10; i <= 13; i++) pulse_e1dr(SR_W'(i), 1'b1);
    sr = SR_W'(14);
    vs_e1dr = 1'b1;
    sb.push_back({exp_ir, sr});
    tick(2);
    cmd_bus.cmd_ready = 1'b1;
    tick(1);
    cmd_bus.cmd_ready = 1'b0;
    check("t4_level_stays4", fifo_level, 4);
    check("t4_no_overflow", overflow, 0);
    vs_e1dr = 1'b0;
    tick(3);
    cmd_bus.cmd_ready = 1'b1;
    tick(6);
    check("t4_sb_empty", sb.size(), 0);
    check("t4_level_drained", fifo_level, 0);

    // 5: input high through reset release, then reset with entries queued
    cmd_bus.cmd_ready = 1'b0;
    reset_n = 1'b0;
    vs_e1dr = 1'b1;
    tick(2);
    reset_n = 1'b1;
    exp_ir = '0;
    tick(8);
    check("t5_no_spurious_valid", cmd_bus.cmd_valid, 0);
    check("t5_no_spurious_level", fifo_level, 0);
    vs_e1dr = 1'b0;
    tick(4);
    pulse_e1dr(SR_W'('h100), 1'b1);
    pulse_e1dr(SR_W'('h101), 1'b1);
    check("t5_level2", fifo_level, 2);
    #1 reset_n = 1'b0;
    #1;
    check("t5_rst_valid", cmd_bus.cmd_valid, 0);
    check("t5_rst_level", fifo_level, 0);
    check("t5_rst_strobes", {take_action, take_no_action}, 0);
    sb.delete();
    tick(2);
    reset_n = 1'b1;
    tick(5);

    // 6: simultaneous update-IR and exit1-DR use the old opcode
    cmd_bus.cmd_ready = 1'b1;
    pulse_uir(2'b01);
    ir_in = 2'b10;
    sr = 38'h21_0000_0006;
    vs_uir = 1'b1;
    vs_e1dr = 1'b1;
    sb.push_back({2'b01, sr});
    tick(3);
    vs_uir = 1'b0;
    vs_e1dr = 1'b0;
    tick(1);
    check("t6_old_op_lane", take_action, 4'b0010);
    tick(2);
    exp_ir = 2'b10;
    pulse_e1dr(38'h21_0000_0007, 1'b1);
    tick(2);
    check("t6_sb_empty", sb.size(), 0);
    check("t6_final_level", fifo_level, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
